// File: rtl/alu_rr_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared ALU arbiter and the result consumer.
interface alu_rr_arbiter_if #(
  parameter int unsigned BUS_WIDTH = 8
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [BUS_WIDTH-1:0] req0_a;
  logic [BUS_WIDTH-1:0] req0_b;
  logic                 req0_cin;
  logic [3:0]           req0_opcode;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [BUS_WIDTH-1:0] req1_a;
  logic [BUS_WIDTH-1:0] req1_b;
  logic                 req1_cin;
  logic [3:0]           req1_opcode;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [BUS_WIDTH-1:0] rsp_y;
  logic                 rsp_carry_out;
  logic                 rsp_borrow;
  logic                 rsp_zero;
  logic                 rsp_parity;
  logic                 rsp_invalid_op;

  // Producers/consumer side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_cin, req1_opcode,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_carry_out, rsp_borrow, rsp_zero, rsp_parity,
    input  rsp_invalid_op,
    output rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_opcode,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_carry_out, rsp_borrow, rsp_zero, rsp_parity,
    output rsp_invalid_op,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a single
// registered response slot tagged by requester id.
module alu_rr_arbiter #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_rr_arbiter_if.slave bus_io
);

  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpAddc = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpInc  = 4'd4;
  localparam logic [3:0] OpDec  = 4'd5;
  localparam logic [3:0] OpAnd  = 4'd6;
  localparam logic [3:0] OpNot  = 4'd7;
  localparam logic [3:0] OpRol  = 4'd8;
  localparam logic [3:0] OpRor  = 4'd9;

  localparam logic [BUS_WIDTH:0] One = {{BUS_WIDTH{1'b0}}, 1'b1};

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [BUS_WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic                 rsp_borrow_q, rsp_borrow_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_parity_q, rsp_parity_d;
  logic                 rsp_invalid_q, rsp_invalid_d;
  // 1 after reset so requester 0 wins the first tie.
  logic                 last_grant_q, last_grant_d;

  logic                 can_accept;
  logic                 grant0, grant1;
  logic                 accept0, accept1, accept;
  logic                 sel;

  logic [BUS_WIDTH-1:0] alu_a, alu_b;
  logic                 alu_cin;
  logic [3:0]           alu_op;
  logic [BUS_WIDTH:0]   alu_sum;
  logic [BUS_WIDTH-1:0] alu_y;
  logic                 alu_carry, alu_borrow, alu_invalid;

  // Slot can take a new op if empty or being drained on this edge.
  assign can_accept = !rsp_valid_q | bus_io.rsp_ready;

  // Round-robin grant: a tie goes to the requester that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case ({bus_io.req1_valid, bus_io.req0_valid})
      2'b01:   grant0 = 1'b1;
      2'b10:   grant1 = 1'b1;
      2'b11: begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end
      default: ;
    endcase
  end

  assign bus_io.req0_ready = grant0 & can_accept & reset_n;
  assign bus_io.req1_ready = grant1 & can_accept & reset_n;
  assign accept0           = bus_io.req0_valid & bus_io.req0_ready;
  assign accept1           = bus_io.req1_valid & bus_io.req1_ready;
  assign accept            = accept0 | accept1;
  assign sel               = accept1;

  // Operand mux feeding the shared ALU.
  always_comb begin
    alu_a   = sel ? bus_io.req1_a      : bus_io.req0_a;
    alu_b   = sel ? bus_io.req1_b      : bus_io.req0_b;
    alu_cin = sel ? bus_io.req1_cin    : bus_io.req0_cin;
    alu_op  = sel ? bus_io.req1_opcode : bus_io.req0_opcode;
  end

  // Combinational ALU; carry/borrow come from the extra MSB of a widened sum.
  always_comb begin
    alu_sum     = '0;
    alu_y       = '0;
    alu_carry   = 1'b0;
    alu_borrow  = 1'b0;
    alu_invalid = 1'b0;
    case (alu_op)
      OpAdd: begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y     = alu_sum[BUS_WIDTH-1:0];
        alu_carry = alu_sum[BUS_WIDTH];
      end
      OpAddc: begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {{BUS_WIDTH{1'b0}}, alu_cin};
        alu_y     = alu_sum[BUS_WIDTH-1:0];
        alu_carry = alu_sum[BUS_WIDTH];
      end
      OpSub: begin
        alu_sum    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_y      = alu_sum[BUS_WIDTH-1:0];
        alu_borrow = alu_sum[BUS_WIDTH];
      end
      OpInc: begin
        alu_sum   = {1'b0, alu_a} + One;
        alu_y     = alu_sum[BUS_WIDTH-1:0];
        alu_carry = alu_sum[BUS_WIDTH];
      end
      OpDec: begin
        alu_sum    = {1'b0, alu_a} - One;
        alu_y      = alu_sum[BUS_WIDTH-1:0];
        alu_borrow = alu_sum[BUS_WIDTH];
      end
      OpAnd:   alu_y = alu_a & alu_b;
      OpNot:   alu_y = ~alu_a;
      OpRol:   alu_y = {alu_a[BUS_WIDTH-2:0], alu_a[BUS_WIDTH-1]};
      OpRor:   alu_y = {alu_a[0], alu_a[BUS_WIDTH-1:1]};
      default: alu_invalid = 1'b1;
    endcase
  end

  // Response slot next state: load on accept, empty on drain, otherwise hold.
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_y_d       = rsp_y_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_borrow_d  = rsp_borrow_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_parity_d  = rsp_parity_q;
    rsp_invalid_d = rsp_invalid_q;
    last_grant_d  = last_grant_q;
    if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = sel;
      rsp_y_d       = alu_y;
      rsp_carry_d   = alu_carry;
      rsp_borrow_d  = alu_borrow;
      rsp_zero_d    = (alu_y == '0);
      rsp_parity_d  = ^alu_y;
      rsp_invalid_d = alu_invalid;
      last_grant_d  = sel;
    end else if (bus_io.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_y_q       <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_borrow_q  <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_parity_q  <= 1'b0;
      rsp_invalid_q <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_y_q       <= rsp_y_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_borrow_q  <= rsp_borrow_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_parity_q  <= rsp_parity_d;
      rsp_invalid_q <= rsp_invalid_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign bus_io.rsp_valid      = rsp_valid_q;
  assign bus_io.rsp_id         = rsp_id_q;
  assign bus_io.rsp_y          = rsp_y_q;
  assign bus_io.rsp_carry_out  = rsp_carry_q;
  assign bus_io.rsp_borrow     = rsp_borrow_q;
  assign bus_io.rsp_zero       = rsp_zero_q;
  assign bus_io.rsp_parity     = rsp_parity_q;
  assign bus_io.rsp_invalid_op = rsp_invalid_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with BUS_WIDTH=8.
module tb_alu_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_rr_arbiter_if #(.BUS_WIDTH(8)) bus ();

  alu_rr_arbiter #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed as {0, valid, id, carry, borrow, zero, parity, invalid, y}.
  task automatic chk_rsp(input string tag, input logic v, input logic id, input logic [7:0] y,
                         input logic c, input logic b, input logic z, input logic p,
                         input logic inv);
    chk(tag, {1'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_carry_out, bus.rsp_borrow, bus.rsp_zero,
              bus.rsp_parity, bus.rsp_invalid_op, bus.rsp_y},
        {1'b0, v, id, c, b, z, p, inv, y});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk(tag, {14'b0, bus.req0_ready, bus.req1_ready}, {14'b0, r0, r1});
  endtask

  task automatic drv(input int id, input logic v, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic cin);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
      bus.req0_cin = cin;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
      bus.req1_cin = cin;
    end
  endtask

  initial begin
    drv(0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    drv(1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk_rsp("reset_state", 0, 0, 8'h00, 0, 0, 0, 0, 0);

    // 1. ADD F0+20 from requester 0.
    reset_n = 1'b1;
    drv(0, 1'b1, 4'd1, 8'hF0, 8'h20, 1'b0);
    #1 chk_rdy("t1_ready", 1, 0);
    tick();
    drv(0, 1'b0, 4'd1, 8'hF0, 8'h20, 1'b0);
    chk_rsp("t1_add", 1, 0, 8'h10, 1, 0, 0, 1, 0);

    // 2. Requester 1 SUB then invalid opcode, then drain.
    drv(1, 1'b1, 4'd3, 8'h05, 8'h07, 1'b0);
    #1 chk_rdy("t2_ready", 0, 1);
    tick();
    chk_rsp("t2_sub", 1, 1, 8'hFE, 0, 1, 0, 1, 0);
    drv(1, 1'b1, 4'd0, 8'h05, 8'h07, 1'b0);
    tick();
    chk_rsp("t2_invalid", 1, 1, 8'h00, 0, 0, 1, 0, 1);
    drv(1, 1'b0, 4'd0, 8'h05, 8'h07, 1'b0);
    tick();
    chk_rsp("t2_drain_hold", 0, 1, 8'h00, 0, 0, 1, 0, 1);

    // 3. Both valid every cycle: ids alternate starting with requester 0.
    drv(0, 1'b1, 4'd4, 8'h0F, 8'h00, 1'b0);
    drv(1, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
    #1 chk_rdy("t3_first_tie", 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk_rsp($sformatf("t3_rr_%0d", i), 1, 0, 8'h10, 0, 0, 0, 1, 0);
        chk_rdy($sformatf("t3_rdy_%0d", i), 0, 1);
      end else begin
        chk_rsp($sformatf("t3_rr_%0d", i), 1, 1, 8'hFF, 0, 1, 0, 0, 0);
        chk_rdy($sformatf("t3_rdy_%0d", i), 1, 0);
      end
    end

    // 4. Backpressure with a tie pending; priority must not flip while stalled.
    bus.rsp_ready = 1'b0;
    drv(0, 1'b1, 4'd6, 8'h3C, 8'h0F, 1'b0);
    drv(1, 1'b1, 4'd7, 8'hAA, 8'h00, 1'b0);
    #1 chk_rdy("t4_stall_rdy", 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("t4_stall_rsp_%0d", i), 1, 1, 8'hFF, 0, 1, 0, 0, 0);
      chk_rdy($sformatf("t4_stall_rdy_%0d", i), 0, 0);
    end
    bus.rsp_ready = 1'b1;
    #1 chk_rdy("t4_release_rdy", 1, 0);
    tick();
    chk_rsp("t4_and", 1, 0, 8'h0C, 0, 0, 0, 0, 0);
    drv(0, 1'b0, 4'd6, 8'h3C, 8'h0F, 1'b0);
    tick();
    chk_rsp("t4_not", 1, 1, 8'h55, 0, 0, 0, 0, 0);
    drv(1, 1'b0, 4'd7, 8'hAA, 8'h00, 1'b0);
    tick();
    chk_rsp("t4_drain", 0, 1, 8'h55, 0, 0, 0, 0, 0);

    // 5. ADD_CARRY wrap, rotates, out-of-range opcode.
    drv(0, 1'b1, 4'd2, 8'hFF, 8'h00, 1'b1);
    tick();
    chk_rsp("t5_addc", 1, 0, 8'h00, 1, 0, 1, 0, 0);
    drv(0, 1'b1, 4'd8, 8'h81, 8'h00, 1'b0);
    tick();
    chk_rsp("t5_rol", 1, 0, 8'h03, 0, 0, 0, 0, 0);
    drv(0, 1'b1, 4'd9, 8'h01, 8'h00, 1'b0);
    tick();
    chk_rsp("t5_ror", 1, 0, 8'h80, 0, 0, 0, 1, 0);
    drv(0, 1'b1, 4'd15, 8'h12, 8'h34, 1'b1);
    tick();
    chk_rsp("t5_op15", 1, 0, 8'h00, 0, 0, 1, 0, 1);

    // 6. Reset while full with both requesters valid; last grant was requester 0.
    bus.rsp_ready = 1'b0;
    drv(0, 1'b1, 4'd1, 8'h01, 8'h01, 1'b0);
    drv(1, 1'b1, 4'd1, 8'h02, 8'h02, 1'b0);
    tick();
    chk_rsp("t6_full", 1, 0, 8'h00, 0, 0, 1, 0, 1);
    reset_n = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 chk_rdy("t6_rst_rdy", 0, 0);
    tick();
    chk_rsp("t6_rst_rsp", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    chk_rdy("t6_rst_rdy2", 0, 0);
    reset_n = 1'b1;
    #1 chk_rdy("t6_tie_after_rst", 1, 0);
    tick();
    chk_rsp("t6_first", 1, 0, 8'h02, 0, 0, 0, 1, 0);
    chk_rdy("t6_next_rdy", 0, 1);
    tick();
    chk_rsp("t6_second", 1, 1, 8'h04, 0, 0, 0, 1, 0);
    drv(0, 1'b0, 4'd1, 8'h01, 8'h01, 1'b0);
    drv(1, 1'b0, 4'd1, 8'h02, 8'h02, 1'b0);
    tick();
    chk_rsp("t6_drain", 0, 1, 8'h04, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
